// File: rtl/imul_req_arbiter.sv
// Round-robin front end that shares one val/rdy multiplier among NREQ clients.
// A tag FIFO remembers who issued each in-flight op so results route back in order.
module imul_req_arbiter #(
  parameter int NREQ         = 2,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_val,
  output logic [NREQ-1:0]    req_rdy,
  input  logic [NREQ*64-1:0] req_msg,
  output logic [NREQ-1:0]    resp_val,
  input  logic [NREQ-1:0]    resp_rdy,
  output logic [31:0]        resp_msg,
  output logic               mul_istream_val,
  input  logic               mul_istream_rdy,
  output logic [63:0]        mul_istream_msg,
  input  logic               mul_ostream_val,
  output logic               mul_ostream_rdy,
  input  logic [31:0]        mul_ostream_msg
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [PW-1:0] r_ptr;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_tags [MAX_INFLIGHT];

  logic          w_found;
  logic [PW-1:0] w_gnt;
  logic          w_not_full;
  logic          w_nonempty;
  logic          w_can_issue;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_tag;

  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req_val[idx]) begin
        w_found = 1'b1;
        w_gnt   = PW'(idx);
      end
    end
  end

  // Occupancy is taken from the register, so a pop never frees a slot
  // for an issue in the same cycle.
  assign w_not_full  = (r_count < CW'(MAX_INFLIGHT));
  assign w_nonempty  = (r_count != '0);
  assign w_can_issue = mul_istream_rdy && w_not_full;
  assign w_push      = w_found && w_can_issue;
  assign w_tag       = r_tags[r_head];

  assign mul_istream_val = (|req_val) && w_not_full;
  assign mul_istream_msg = w_found ? req_msg[64*w_gnt +: 64] : 64'd0;
  assign req_rdy         = w_push ? (NREQ'(1) << w_gnt) : '0;

  assign mul_ostream_rdy = w_nonempty && resp_rdy[w_tag];
  assign w_pop           = mul_ostream_val && mul_ostream_rdy;
  assign resp_msg        = mul_ostream_msg;
  assign resp_val        = (mul_ostream_val && w_nonempty)
                         ? (NREQ'(1) << w_tag) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_ptr  <= (w_gnt == PW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
        r_tail <= (r_tail == AW'(MAX_INFLIGHT - 1)) ? '0 : r_tail + 1'b1;
      end
      if (w_pop)
        r_head <= (r_head == AW'(MAX_INFLIGHT - 1)) ? '0 : r_head + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_tags[r_tail] <= w_gnt;
  end

endmodule
